// File: rtl/nbdcache_pkg.sv
// Shared non-blocking data cache types: cache line layout, byte enables and tag width.
package nbdcache_pkg;

    localparam int TAG_WIDTH  = 8;
    localparam int LINE_WIDTH = 32;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] data;
        logic                  dirty;
        logic                  valid;
    } cache_line_t;

    typedef struct packed {
        logic [TAG_WIDTH/8-1:0]  tag;
        logic [LINE_WIDTH/8-1:0] data;
        logic                    dirty;
        logic                    valid;
    } cl_be_t;

    // arb_mode: TAG_CMP_ARB_ROUND_ROBIN_EN selects round-robin arbitration,
    // otherwise fixed priority with the lowest port index winning.

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tag_cmp_arb_rr_arb_sel.sv
// Combinational winner select: first requester at or after ptr_i, wrapping modulo N.
module rr_arb_sel #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Upper segment [ptr, N) first, then the wrapped segment [0, ptr).
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= 32'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tag_cmp_arb.sv
// Multi-port SRAM arbiter with lock and one-cycle tag compare.
// Define TAG_CMP_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority.
module tag_cmp_arb
    import nbdcache_pkg::*;
#(
    parameter int unsigned NR_PORTS          = 4,
    parameter int unsigned ADDR_WIDTH        = 12,
    parameter int unsigned SET_ASSOCIATIVITY = 8,
    parameter type         data_t            = cache_line_t,
    parameter type         be_t              = cl_be_t,
    localparam int unsigned ID_W             = idx_width(NR_PORTS)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NR_PORTS-1:0][SET_ASSOCIATIVITY-1:0]  req_i,
    input  logic [NR_PORTS-1:0]                         lock_i,
    output logic [NR_PORTS-1:0]                         gnt_o,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]         addr_i,
    input  data_t [NR_PORTS-1:0]                        wdata_i,
    input  logic [NR_PORTS-1:0]                         we_i,
    input  be_t [NR_PORTS-1:0]                          be_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]          tag_i,
    output data_t [SET_ASSOCIATIVITY-1:0]               rdata_o,
    output logic [SET_ASSOCIATIVITY-1:0]                hit_way_o,
    output logic                                        hit_valid_o,
    output logic [ID_W-1:0]                             hit_id_o,
    output logic                                        multi_hit_o,
    output logic [SET_ASSOCIATIVITY-1:0]                req_o,
    output logic [ADDR_WIDTH-1:0]                       addr_o,
    output data_t                                       wdata_o,
    output logic                                        we_o,
    output be_t                                         be_o,
    input  data_t [SET_ASSOCIATIVITY-1:0]               rdata_i
);

    logic [NR_PORTS-1:0] req_any;
    logic [NR_PORTS-1:0] sel_gnt;
    logic [ID_W-1:0]     sel_idx;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gnt_idx;
    logic                granted;
    logic                lock_hold;
    logic                hit_en;

    logic [ID_W-1:0]     id_q;
    logic                valid_q;
    logic                we_q;
    logic                lock_q;
    logic [ID_W-1:0]     lock_id_q;

    genvar gi;
    generate
        for (gi = 0; gi < NR_PORTS; gi++) begin : g_req_any
            assign req_any[gi] = |req_i[gi];
        end
    endgenerate

`ifdef TAG_CMP_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    rr_arb_sel #(
        .N     (NR_PORTS),
        .IDX_W (ID_W)
    ) u_rr_arb_sel (
        .req_i (req_any),
        .ptr_i (rr_ptr),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx)
    );

    // A held lock releases as soon as its owner stops requesting.
    assign lock_hold = lock_q & req_any[lock_id_q];

    always_comb begin
        gnt_o   = sel_gnt;
        gnt_idx = sel_idx;
        if (lock_hold) begin
            gnt_o            = '0;
            gnt_o[lock_id_q] = 1'b1;
            gnt_idx          = lock_id_q;
        end
    end

    assign granted = |gnt_o;

    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        if (granted) begin
            req_o   = req_i[gnt_idx];
            addr_o  = addr_i[gnt_idx];
            wdata_o = wdata_i[gnt_idx];
            we_o    = we_i[gnt_idx];
            be_o    = be_i[gnt_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q      <= '0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            valid_q   <= granted;
            lock_q    <= granted & lock_i[gnt_idx];
            lock_id_q <= gnt_idx;
            if (granted) begin
                id_q <= gnt_idx;
                we_q <= we_i[gnt_idx];
            end
        end
    end

`ifdef TAG_CMP_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (granted && !lock_hold) begin
            rr_ptr_q <= (gnt_idx == ID_W'(NR_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    // Writes never report hits, so the compare is gated like hit_valid_o.
    assign hit_en = valid_q & ~we_q;

    generate
        for (gi = 0; gi < SET_ASSOCIATIVITY; gi++) begin : g_hit
            assign hit_way_o[gi] = hit_en & rdata_i[gi].valid
                                 & (tag_i[id_q] == rdata_i[gi].tag);
        end
    endgenerate

    assign hit_valid_o = hit_en;
    assign hit_id_o    = id_q;
    assign multi_hit_o = hit_en & ((hit_way_o & (hit_way_o - 1'b1)) != '0);
    assign rdata_o     = rdata_i;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) assert ($onehot0(gnt_o));
    end
`endif

endmodule

// File: tb/tb_tag_cmp_arb.sv
// Directed bench for tag_cmp_arb; expectations follow TAG_CMP_ARB_ROUND_ROBIN_EN.
module tb_tag_cmp_arb;
    import nbdcache_pkg::*;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int SA = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic [NP-1:0][SA-1:0]       req_i;
    logic [NP-1:0]               lock_i;
    logic [NP-1:0]               gnt_o;
    logic [NP-1:0][AW-1:0]       addr_i;
    cache_line_t [NP-1:0]        wdata_i;
    logic [NP-1:0]               we_i;
    cl_be_t [NP-1:0]             be_i;
    logic [NP-1:0][TAG_WIDTH-1:0] tag_i;
    cache_line_t [SA-1:0]        rdata_o;
    logic [SA-1:0]               hit_way_o;
    logic                        hit_valid_o;
    logic [1:0]                  hit_id_o;
    logic                        multi_hit_o;
    logic [SA-1:0]               req_o;
    logic [AW-1:0]               addr_o;
    cache_line_t                 wdata_o;
    logic                        we_o;
    cl_be_t                      be_o;
    cache_line_t [SA-1:0]        rdata_i;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    cache_line_t exp_line;
    cl_be_t      exp_be;
    logic [3:0]  exp_gnt;

    always #5 clk_i = ~clk_i;

    tag_cmp_arb #(
        .NR_PORTS          (NP),
        .ADDR_WIDTH        (AW),
        .SET_ASSOCIATIVITY (SA)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .tag_i       (tag_i),
        .rdata_o     (rdata_o),
        .hit_way_o   (hit_way_o),
        .hit_valid_o (hit_valid_o),
        .hit_id_o    (hit_id_o),
        .multi_hit_o (multi_hit_o),
        .req_o       (req_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .we_o        (we_o),
        .be_o        (be_o),
        .rdata_i     (rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_i   = '0;
        lock_i  = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
    endtask

    task automatic all_request();
        for (int p = 0; p < NP; p++) req_i[p] = 8'h01;
    endtask

    initial begin
        // Constant cache contents: way 3 holds 0x5A, ways 0 and 5 hold 0x33.
        rdata_i = '0;
        rdata_i[3].tag   = 8'h5A; rdata_i[3].valid = 1'b1; rdata_i[3].data = 32'h1234_5678;
        rdata_i[0].tag   = 8'h33; rdata_i[0].valid = 1'b1;
        rdata_i[5].tag   = 8'h33; rdata_i[5].valid = 1'b1;
        tag_i[0] = 8'h33;
        tag_i[1] = 8'h5A;
        tag_i[2] = 8'h5A;
        tag_i[3] = 8'h77;

        // Reset: combinational path follows req_i, registered outputs are zero.
        rst_ni = 1'b0;
        clear_inputs();
        req_i[1]  = 8'h03;
        addr_i[1] = 12'h123;
        #2;
        check("rst_gnt", 64'(gnt_o), 64'(4'b0010));
        check("rst_req_o", 64'(req_o), 64'(8'h03));
        check("rst_addr_o", 64'(addr_o), 64'(12'h123));
        check("rst_hit_valid", 64'(hit_valid_o), 64'(1'b0));
        check("rst_hit_way", 64'(hit_way_o), 64'(8'h00));
        check("rst_hit_id", 64'(hit_id_o), 64'(2'd0));
        check("rst_multi", 64'(multi_hit_o), 64'(1'b0));
        tick();
        tick();
        check("rst_clk_hit_valid", 64'(hit_valid_o), 64'(1'b0));

        // Idle: every SRAM-side output is zero.
        rst_ni = 1'b1;
        clear_inputs();
        #1;
        check("idle_gnt", 64'(gnt_o), 64'(4'b0000));
        check("idle_req_o", 64'(req_o), 64'(8'h00));
        check("idle_addr_o", 64'(addr_o), 64'(12'h000));
        check("idle_we_o", 64'(we_o), 64'(1'b0));
        check("idle_wdata_o", 64'(wdata_o), 64'(0));
        check("idle_be_o", 64'(be_o), 64'(0));
        tick();

        // Port 1 read, tag 0x5A matches way 3.
        req_i[1]  = 8'h01;
        addr_i[1] = 12'hABC;
        #1;
        check("rd_gnt", 64'(gnt_o), 64'(4'b0010));
        check("rd_req_o", 64'(req_o), 64'(8'h01));
        check("rd_addr_o", 64'(addr_o), 64'(12'hABC));
        tick();
        clear_inputs();
        #1;
        check("rd_hit_way", 64'(hit_way_o), 64'(8'h08));
        check("rd_hit_valid", 64'(hit_valid_o), 64'(1'b1));
        check("rd_hit_id", 64'(hit_id_o), 64'(2'd1));
        check("rd_multi", 64'(multi_hit_o), 64'(1'b0));
        check("rdata_pass", 64'(rdata_o[3].data), 64'(32'h1234_5678));

        // Port 2 write: tag would match way 3, but writes report no hit.
        exp_line = '{tag: 8'hC3, data: 32'hDEAD_BEEF, dirty: 1'b1, valid: 1'b1};
        exp_be   = '{tag: 1'b1, data: 4'b1010, dirty: 1'b0, valid: 1'b1};
        req_i[2]   = 8'h10;
        we_i[2]    = 1'b1;
        wdata_i[2] = exp_line;
        be_i[2]    = exp_be;
        addr_i[2]  = 12'h456;
        #1;
        check("wr_gnt", 64'(gnt_o), 64'(4'b0100));
        check("wr_we_o", 64'(we_o), 64'(1'b1));
        check("wr_wdata_o", 64'(wdata_o), 64'(exp_line));
        check("wr_be_o", 64'(be_o), 64'(exp_be));
        check("wr_addr_o", 64'(addr_o), 64'(12'h456));
        tick();
        clear_inputs();
        #1;
        check("wr_hit_valid", 64'(hit_valid_o), 64'(1'b0));
        check("wr_hit_way", 64'(hit_way_o), 64'(8'h00));
        check("wr_hit_id", 64'(hit_id_o), 64'(2'd2));

        // Port 0 read, tag 0x33 matches ways 0 and 5.
        req_i[0] = 8'hFF;
        #1;
        check("mh_gnt", 64'(gnt_o), 64'(4'b0001));
        tick();
        clear_inputs();
        #1;
        check("mh_hit_way", 64'(hit_way_o), 64'(8'h21));
        check("mh_multi", 64'(multi_hit_o), 64'(1'b1));
        check("mh_hit_id", 64'(hit_id_o), 64'(2'd0));

        // Reset pulse between edges restarts arbitration from port 0.
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        #1;

        // All ports request for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            all_request();
`ifdef TAG_CMP_ARB_ROUND_ROBIN_EN
            exp_gnt = 4'(1 << (i % 4));
`else
            exp_gnt = 4'b0001;
`endif
            #1;
            check($sformatf("all_req_gnt[%0d]", i), 64'(gnt_o), 64'(exp_gnt));
            tick();
        end

        // Lock: port 2 keeps the grant for 4 cycles against 0, 1 and 3.
        clear_inputs();
        req_i[2]  = 8'h01;
        lock_i[2] = 1'b1;
        #1;
        check("lock_gnt[0]", 64'(gnt_o), 64'(4'b0100));
        tick();
        for (int i = 1; i < 4; i++) begin
            all_request();
            lock_i[2] = (i < 3);
            #1;
            check($sformatf("lock_gnt[%0d]", i), 64'(gnt_o), 64'(4'b0100));
            tick();
        end
        lock_i = '0;
        all_request();
        #1;
`ifdef TAG_CMP_ARB_ROUND_ROBIN_EN
        check("lock_after", 64'(gnt_o), 64'(4'b1000));
`else
        check("lock_after", 64'(gnt_o), 64'(4'b0001));
`endif
        tick();

        // Ports 1 and 3 request.
        clear_inputs();
        req_i[1] = 8'h01;
        req_i[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
`ifdef TAG_CMP_ARB_ROUND_ROBIN_EN
            exp_gnt = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`else
            exp_gnt = 4'b0010;
`endif
            #1;
            check($sformatf("p13_gnt[%0d]", i), 64'(gnt_o), 64'(exp_gnt));
            tick();
        end

        // Locked port drops its request: lock releases in the same cycle.
        clear_inputs();
        req_i[2]  = 8'h01;
        lock_i[2] = 1'b1;
        #1;
        check("rel_gnt0", 64'(gnt_o), 64'(4'b0100));
        tick();
        clear_inputs();
        req_i[1] = 8'h01;
        #1;
        check("rel_gnt1", 64'(gnt_o), 64'(4'b0010));
        tick();

        // Reset asserted mid-lock.
        clear_inputs();
        req_i[2]  = 8'h01;
        lock_i[2] = 1'b1;
        #1;
        check("rl_gnt_pre", 64'(gnt_o), 64'(4'b0100));
        tick();
        clear_inputs();
        all_request();
        rst_ni = 1'b0;
        #1;
        check("rl_gnt_in_rst", 64'(gnt_o), 64'(4'b0001));
        check("rl_hit_valid_in_rst", 64'(hit_valid_o), 64'(1'b0));
        tick();
        rst_ni = 1'b1;
        #1;
        check("rl_gnt_post", 64'(gnt_o), 64'(4'b0001));
        check("rl_hit_valid_post", 64'(hit_valid_o), 64'(1'b0));
        tick();
        check("rl_hit_valid_next", 64'(hit_valid_o), 64'(1'b1));
        check("rl_hit_id_next", 64'(hit_id_o), 64'(2'd0));
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
